// File: rtl/drs_pkg.sv
// Shared DRS4 pin constants and readout sequencer state encoding.
package drs_pkg;

    localparam logic [3:0] ADDR_STANDBY = 4'b1111;
    localparam logic [3:0] ADDR_ALL     = 4'b1001;
    localparam logic [3:0] ADDR_CFG     = 4'b1100;
    localparam logic [3:0] ADDR_WSR     = 4'b1101;

    localparam int STOP_CELL_BITS = 10;

    typedef enum logic [2:0] {
        IDLE,
        STOP,
        LOAD,
        READ,
        DRAIN,
        DONE
    } drs_state_e;

endpackage

// File: rtl/adc_strobe_delay.sv
// Delays an SRCLK strobe and its sample index by the ADC pipeline latency.
module adc_strobe_delay #(
    parameter int LATENCY = 7,
    parameter int IDX_W   = 10
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             strobe_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic             strobe_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [LATENCY-1:0] vld_p;
    logic [IDX_W-1:0]   idx_p [LATENCY];

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= strobe_i;
            for (int i = 1; i < LATENCY; i++) vld_p[i] <= vld_p[i-1];
        end
    end

    // Index rides alongside the strobe; only the strobe needs a reset.
    always_ff @(posedge clock_i) begin
        idx_p[0] <= idx_i;
        for (int i = 1; i < LATENCY; i++) idx_p[i] <= idx_p[i-1];
    end

    assign strobe_o = vld_p[LATENCY-1];
    assign idx_o    = idx_p[LATENCY-1];

endmodule

// File: rtl/drs_readout_seq.sv
// DRS4 readout sequencer: stops the domino wave, shifts out NSAMPLES cells,
// captures the matching ADC words and recovers the stop cell from SROUT.
module drs_readout_seq
    import drs_pkg::*;
#(
    parameter int NSAMPLES    = 1024,
    parameter int ADC_BITS    = 14,
    parameter int ADC_LATENCY = 7,
    parameter int SRCLK_HALF  = 1,
    parameter int STOP_WAIT   = 4
) (
    input  logic                        clock_i,
    input  logic                        reset_i,
    input  logic                        enable_i,
    input  logic                        trigger_i,
    input  logic [3:0]                  ch_sel_i,
    input  logic [ADC_BITS-1:0]         adc_data_i,
    input  logic                        drs_srout_i,
    output logic [3:0]                  drs_addr_o,
    output logic                        drs_denable_o,
    output logic                        drs_dwrite_o,
    output logic                        drs_rsrload_o,
    output logic                        drs_srclk_o,
    output logic                        drs_srin_o,
    output logic [ADC_BITS-1:0]         data_o,
    output logic                        data_valid_o,
    output logic [$clog2(NSAMPLES)-1:0] sample_idx_o,
    output logic                        last_o,
    output logic [STOP_CELL_BITS-1:0]   stop_cell_o,
    output logic                        stop_cell_valid_o,
    output logic                        busy_o,
    output logic                        done_o
);

    localparam int IDX_W = $clog2(NSAMPLES);
    localparam int SC_W  = IDX_W + 1;
    localparam int CNT_W = $clog2(STOP_WAIT + 2*SRCLK_HALF + ADC_LATENCY + 1);
    localparam int SCC_W = $clog2(STOP_CELL_BITS + 1);

    localparam logic [CNT_W-1:0] STOP_LAST   = CNT_W'(STOP_WAIT - 1);
    localparam logic [CNT_W-1:0] LOAD_LAST   = CNT_W'(2*SRCLK_HALF - 1);
    localparam logic [CNT_W-1:0] HALF_LAST   = CNT_W'(SRCLK_HALF - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(ADC_LATENCY - 1);
    localparam logic [SC_W-1:0]  STROBE_TERM = SC_W'(NSAMPLES);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NSAMPLES - 1);
    localparam logic [SCC_W-1:0] SCC_LAST    = SCC_W'(STOP_CELL_BITS - 1);

    drs_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SC_W-1:0]  strb_cnt_q, strb_cnt_d;
    logic [3:0]       ch_q, ch_d;
    logic             strobe_q, strobe_d;
    logic             srclk_d, denable_d, dwrite_d, rsrload_d, busy_d, done_d;
    logic [3:0]       addr_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        strb_cnt_d = strb_cnt_q;
        ch_d       = ch_q;
        strobe_d   = 1'b0;
        srclk_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (trigger_i && enable_i) begin
                    state_d    = STOP;
                    ch_d       = ch_sel_i;
                    strb_cnt_d = '0;
                end
            end
            STOP: begin
                if (cnt_q == STOP_LAST) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end else cnt_d = cnt_q + 1'b1;
            end
            LOAD: begin
                if (cnt_q == LOAD_LAST) begin
                    state_d    = READ;
                    cnt_d      = '0;
                    srclk_d    = 1'b1;
                    strobe_d   = 1'b1;
                    strb_cnt_d = strb_cnt_q + 1'b1;
                end else cnt_d = cnt_q + 1'b1;
            end
            READ: begin
                srclk_d = drs_srclk_o;
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (drs_srclk_o) begin
                        srclk_d = 1'b0;
                    end else if (strb_cnt_q == STROBE_TERM) begin
                        state_d = DRAIN;
                    end else begin
                        srclk_d    = 1'b1;
                        strobe_d   = 1'b1;
                        strb_cnt_d = strb_cnt_q + 1'b1;
                    end
                end else cnt_d = cnt_q + 1'b1;
            end
            DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else cnt_d = cnt_q + 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Pin values follow the state being entered so they register in step with it.
        addr_d    = ADDR_STANDBY;
        denable_d = drs_denable_o;
        dwrite_d  = 1'b0;
        rsrload_d = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        unique case (state_d)
            IDLE: begin
                denable_d = enable_i;
                dwrite_d  = enable_i;
            end
            STOP: busy_d = 1'b1;
            LOAD: begin
                busy_d    = 1'b1;
                addr_d    = ch_d;
                rsrload_d = 1'b1;
            end
            READ, DRAIN: begin
                busy_d = 1'b1;
                addr_d = ch_d;
            end
            DONE: begin
                denable_d = enable_i;
                dwrite_d  = enable_i;
                done_d    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            strb_cnt_q    <= '0;
            ch_q          <= '0;
            strobe_q      <= 1'b0;
            drs_addr_o    <= ADDR_STANDBY;
            drs_denable_o <= 1'b0;
            drs_dwrite_o  <= 1'b0;
            drs_rsrload_o <= 1'b0;
            drs_srclk_o   <= 1'b0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            strb_cnt_q    <= strb_cnt_d;
            ch_q          <= ch_d;
            strobe_q      <= strobe_d;
            drs_addr_o    <= addr_d;
            drs_denable_o <= denable_d;
            drs_dwrite_o  <= dwrite_d;
            drs_rsrload_o <= rsrload_d;
            drs_srclk_o   <= srclk_d;
            busy_o        <= busy_d;
            done_o        <= done_d;
        end
    end

    assign drs_srin_o = 1'b0;

    logic             dly_strobe;
    logic [IDX_W-1:0] dly_idx;

    adc_strobe_delay #(
        .LATENCY (ADC_LATENCY),
        .IDX_W   (IDX_W)
    ) u_strobe_delay (
        .clock_i  (clock_i),
        .reset_i  (reset_i),
        .strobe_i (strobe_d),
        .idx_i    (strb_cnt_q[IDX_W-1:0]),
        .strobe_o (dly_strobe),
        .idx_o    (dly_idx)
    );

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            data_o       <= '0;
            data_valid_o <= 1'b0;
            sample_idx_o <= '0;
            last_o       <= 1'b0;
        end else begin
            data_valid_o <= dly_strobe;
            last_o       <= dly_strobe && (dly_idx == IDX_LAST);
            if (dly_strobe) begin
                data_o       <= adc_data_i;
                sample_idx_o <= dly_idx;
            end
        end
    end

    // SROUT is sampled while SRCLK is high, first bit lands in the MSB.
    logic [SCC_W-1:0]          sc_cnt_q;
    logic [STOP_CELL_BITS-2:0] sc_shift_q;

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            sc_cnt_q          <= '0;
            sc_shift_q        <= '0;
            stop_cell_o       <= '0;
            stop_cell_valid_o <= 1'b0;
        end else begin
            stop_cell_valid_o <= 1'b0;
            if (state_q == IDLE) begin
                sc_cnt_q <= '0;
            end else if (strobe_q && sc_cnt_q <= SCC_LAST) begin
                sc_shift_q <= {sc_shift_q[STOP_CELL_BITS-3:0], drs_srout_i};
                sc_cnt_q   <= sc_cnt_q + 1'b1;
                if (sc_cnt_q == SCC_LAST) begin
                    stop_cell_o       <= {sc_shift_q, drs_srout_i};
                    stop_cell_valid_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_drs_readout_seq.sv
// Directed bench for the DRS4 readout sequencer (16 samples, latency 7).
module tb_drs_readout_seq;

    localparam int NS  = 16;
    localparam int AB  = 14;
    localparam int LAT = 7;
    localparam int SH  = 1;
    localparam int SW  = 4;
    localparam int IW  = 4;

    logic          clock_i = 1'b0;
    logic          reset_i = 1'b0;
    logic          enable_i = 1'b0;
    logic          trigger_i = 1'b0;
    logic [3:0]    ch_sel_i = 4'h0;
    logic [AB-1:0] adc_data_i = '0;
    logic          drs_srout_i = 1'b0;
    logic [3:0]    drs_addr_o;
    logic          drs_denable_o, drs_dwrite_o, drs_rsrload_o, drs_srclk_o, drs_srin_o;
    logic [AB-1:0] data_o;
    logic          data_valid_o;
    logic [IW-1:0] sample_idx_o;
    logic          last_o;
    logic [9:0]    stop_cell_o;
    logic          stop_cell_valid_o, busy_o, done_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    drs_readout_seq #(
        .NSAMPLES(NS), .ADC_BITS(AB), .ADC_LATENCY(LAT), .SRCLK_HALF(SH), .STOP_WAIT(SW)
    ) dut (
        .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable_i), .trigger_i(trigger_i),
        .ch_sel_i(ch_sel_i), .adc_data_i(adc_data_i), .drs_srout_i(drs_srout_i),
        .drs_addr_o(drs_addr_o), .drs_denable_o(drs_denable_o), .drs_dwrite_o(drs_dwrite_o),
        .drs_rsrload_o(drs_rsrload_o), .drs_srclk_o(drs_srclk_o), .drs_srin_o(drs_srin_o),
        .data_o(data_o), .data_valid_o(data_valid_o), .sample_idx_o(sample_idx_o),
        .last_o(last_o), .stop_cell_o(stop_cell_o), .stop_cell_valid_o(stop_cell_valid_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    initial forever #5 clock_i = ~clock_i;
    initial forever begin @(posedge clock_i); cyc++; end
    initial forever begin @(negedge clock_i); adc_data_i = adc_data_i + 1'b1; end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        n_checks++;
        if (drs_addr_o !== 4'b1111) begin
            n_fail++; $display("FAIL reset_addr: got %b required 1111", drs_addr_o);
        end
        n_checks++;
        if ({drs_denable_o, drs_dwrite_o, drs_rsrload_o, drs_srclk_o, drs_srin_o} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_pins: got %b required 00000",
                     {drs_denable_o, drs_dwrite_o, drs_rsrload_o, drs_srclk_o, drs_srin_o});
        end
        n_checks++;
        if ({data_o, sample_idx_o, stop_cell_o} !== '0) begin
            n_fail++; $display("FAIL reset_data: data %h idx %0d stop %h required all 0", data_o, sample_idx_o, stop_cell_o);
        end
        n_checks++;
        if ({data_valid_o, last_o, stop_cell_valid_o, busy_o, done_o} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_status: got %b required 00000",
                     {data_valid_o, last_o, stop_cell_valid_o, busy_o, done_o});
        end
    endtask

    task automatic test_enable();
        reset_i = 1'b1;
        tick();
        enable_i = 1'b1;
        tick();
        n_checks++;
        if ({drs_denable_o, drs_dwrite_o, drs_addr_o} !== {2'b11, 4'b1111}) begin
            n_fail++; $display("FAIL enable_pins: den %b dw %b addr %b required 1 1 1111", drs_denable_o, drs_dwrite_o, drs_addr_o);
        end
        n_checks++;
        if ({data_valid_o, busy_o, done_o} !== 3'b000) begin
            n_fail++; $display("FAIL enable_status: got %b required 000", {data_valid_o, busy_o, done_o});
        end
    endtask

    // Runs one triggered event; if stop_at_rise > 0, reset is pulled low at that strobe.
    task automatic run_event(input logic [3:0] ch, input logic [3:0] ch_late, input logic [9:0] sc,
                             input bit poke, input int stop_at_rise);
        int rise_cyc[$];
        int rise_adc[$];
        int nrise = 0, nval = 0, nsc = 0, rise10 = -1, lv_cyc = -1;
        int bad_ctl = 0, bad_addr = 0, extra = 0, rc, ra;
        bit prev_srclk = 1'b0, done_seen = 1'b0;
        logic [AB-1:0] exp_data;
        logic [IW-1:0] exp_idx;
        logic          exp_last;
        ch_sel_i  = ch;
        trigger_i = 1'b1;
        tick();
        trigger_i = 1'b0;
        for (int t = 0; t < 400 && !done_seen; t++) begin
            if (drs_srclk_o && !prev_srclk) begin
                nrise++;
                rise_cyc.push_back(cyc);
                rise_adc.push_back(int'(adc_data_i));
                if (nrise <= 10) drs_srout_i = sc[10-nrise];
                if (nrise == 10) rise10 = cyc;
                if (nrise == 2) ch_sel_i = ch_late;
                if (poke && nrise == 3) trigger_i = 1'b1;
                if (nrise == stop_at_rise) begin
                    reset_i = 1'b0;
                    #1;
                    return;
                end
            end else begin
                trigger_i = 1'b0;
            end
            prev_srclk = drs_srclk_o;
            if (done_o) begin
                done_seen = 1'b1;
                n_checks++;
                if (busy_o !== 1'b0 || nval != NS || lv_cyc < 0 || cyc <= lv_cyc) begin
                    n_fail++;
                    $display("FAIL done_pulse: busy %b valids %0d last@%0d done@%0d required busy 0, %0d valids before done",
                             busy_o, nval, lv_cyc, cyc, NS);
                end
            end else begin
                if (busy_o !== 1'b1 || drs_dwrite_o !== 1'b0) bad_ctl++;
                if (nrise > 0 && drs_addr_o !== ch) bad_addr++;
            end
            if (data_valid_o) begin
                if (rise_cyc.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL valid_orphan: valid at cycle %0d idx %0d required a preceding strobe", cyc, sample_idx_o);
                end else begin
                    rc = rise_cyc.pop_front();
                    ra = rise_adc.pop_front();
                    exp_data = AB'(ra + LAT);
                    exp_idx  = IW'(nval);
                    exp_last = (nval == NS - 1);
                    n_checks++;
                    if (cyc != rc + LAT || data_o !== exp_data || sample_idx_o !== exp_idx || last_o !== exp_last) begin
                        n_fail++;
                        $display("FAIL sample_%0d: cycle %0d data %h idx %0d last %b required cycle %0d data %h idx %0d last %b",
                                 nval, cyc, data_o, sample_idx_o, last_o, rc + LAT, exp_data, exp_idx, exp_last);
                    end
                end
                lv_cyc = cyc;
                nval++;
            end
            if (stop_cell_valid_o) begin
                nsc++;
                n_checks++;
                if (stop_cell_o !== sc || cyc != rise10 + 1) begin
                    n_fail++;
                    $display("FAIL stop_cell: got %h at cycle %0d required %h at cycle %0d", stop_cell_o, cyc, sc, rise10 + 1);
                end
            end
            tick();
        end
        trigger_i = 1'b0;
        if (!done_seen) begin
            n_checks++; n_fail++;
            $display("FAIL event_timeout: no done_o within 400 cycles, valids %0d required %0d", nval, NS);
        end
        n_checks++;
        if (nval != NS) begin
            n_fail++; $display("FAIL valid_count: got %0d required %0d", nval, NS);
        end
        n_checks++;
        if (nsc != 1) begin
            n_fail++; $display("FAIL stop_cell_pulses: got %0d required 1", nsc);
        end
        n_checks++;
        if (bad_ctl != 0) begin
            n_fail++; $display("FAIL busy_dwrite: %0d cycles with busy!=1 or dwrite!=0, required 0", bad_ctl);
        end
        n_checks++;
        if (bad_addr != 0) begin
            n_fail++; $display("FAIL addr_latched: %0d cycles with addr!=%h, required 0", bad_addr, ch);
        end
        tick();
        n_checks++;
        if ({drs_addr_o, busy_o, done_o, drs_dwrite_o, drs_denable_o} !== {4'b1111, 2'b00, enable_i, enable_i}) begin
            n_fail++;
            $display("FAIL after_done: addr %b busy %b done %b dw %b den %b required 1111 0 0 %b %b",
                     drs_addr_o, busy_o, done_o, drs_dwrite_o, drs_denable_o, enable_i, enable_i);
        end
        repeat (5) begin
            if (data_valid_o || busy_o) extra++;
            tick();
        end
        n_checks++;
        if (extra != 0) begin
            n_fail++; $display("FAIL idle_quiet: %0d active cycles after event, required 0", extra);
        end
    endtask

    task automatic test_readout();
        run_event(4'h3, 4'h7, 10'h2A5, 1'b1, 0);
    endtask

    task automatic test_disabled_trigger();
        int act = 0;
        enable_i = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({drs_denable_o, drs_dwrite_o} !== 2'b00) begin
            n_fail++; $display("FAIL disable_pins: got %b required 00", {drs_denable_o, drs_dwrite_o});
        end
        trigger_i = 1'b1;
        tick();
        trigger_i = 1'b0;
        repeat (20) begin
            if (busy_o || data_valid_o || done_o || drs_dwrite_o) act++;
            tick();
        end
        n_checks++;
        if (act != 0) begin
            n_fail++; $display("FAIL disabled_trigger: %0d active cycles, required 0", act);
        end
        enable_i = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_event();
        run_event(4'h5, 4'h5, 10'h000, 1'b0, 5);
        n_checks++;
        if ({drs_addr_o, drs_denable_o, drs_dwrite_o, drs_rsrload_o, drs_srclk_o, drs_srin_o} !== 9'b1111_00000) begin
            n_fail++;
            $display("FAIL midreset_pins: got %b required 111100000",
                     {drs_addr_o, drs_denable_o, drs_dwrite_o, drs_rsrload_o, drs_srclk_o, drs_srin_o});
        end
        n_checks++;
        if ({data_valid_o, last_o, stop_cell_valid_o, busy_o, done_o} !== 5'b0 ||
            {data_o, sample_idx_o, stop_cell_o} !== '0) begin
            n_fail++;
            $display("FAIL midreset_status: flags %b data %h idx %0d stop %h required all 0",
                     {data_valid_o, last_o, stop_cell_valid_o, busy_o, done_o}, data_o, sample_idx_o, stop_cell_o);
        end
        tick();
        tick();
        reset_i = 1'b1;
        tick();
        tick();
        run_event(4'hA, 4'hA, 10'h15A, 1'b0, 0);
    endtask

    task automatic test_second_event();
        run_event(4'hC, 4'h1, 10'h0F3, 1'b0, 0);
    endtask

    initial begin
        test_reset();
        test_enable();
        test_readout();
        test_disabled_trigger();
        test_reset_mid_event();
        test_second_event();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
